// File: rtl/pipe_pkg.sv
// Shared definitions for the fetch stage: redirect selects, FSM states, IF/ID layout.
// Pure declarations; no logic, no latency, no flow control.
// Every type and constant the fetch unit and its IF/ID register agree on lives here.
package pipe_pkg;

    localparam logic [1:0] PCS_SEQ = 2'b00;
    localparam logic [1:0] PCS_BR  = 2'b01;
    localparam logic [1:0] PCS_JR  = 2'b10;
    localparam logic [1:0] PCS_J   = 2'b11;

    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        FS_FETCH = 1'b0,
        FS_HOLD  = 1'b1
    } fstate_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] dpc4;
        logic        dvalid;
    } ifid_t;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register {inst, dpc4, dvalid} with enable and bubble load.
// Latency: one cycle from load to output.
// Backpressure: en=0 holds every field; a bubble keeps dpc4 and clears dvalid.
module if_id_reg
    import pipe_pkg::*;
#(
    parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        en,
    input  logic        bubble,
    input  logic [31:0] inst_d,
    input  logic [31:0] dpc4_d,
    output ifid_t       q
);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            q <= '{inst: NOP_INST, dpc4: 32'h0, dvalid: 1'b0};
        end else if (en) begin
            if (bubble) begin
                q <= '{inst: NOP_INST, dpc4: q.dpc4, dvalid: 1'b0};
            end else begin
                q <= '{inst: inst_d, dpc4: dpc4_d, dvalid: 1'b1};
            end
        end
    end

endmodule

// File: rtl/pipe_fetch_unit.sv
// IF stage: PC, variable-latency imem req/ack, one-word skid, delayed-branch redirect.
// Latency: ack at cycle N with wpcir=1 shows in IF/ID at N+1.
// Backpressure: wpcir=0 parks a returned word in the skid and drops imem_req until ID accepts it.
module pipe_fetch_unit
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        wpcir,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] da,
    input  logic [31:0] jpc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] dpc4,
    output logic        dvalid
);

    fstate_t     state, state_nxt;
    logic [31:0] pc, pc_nxt, pc4;
    logic [31:0] skid;
    logic [31:0] tgt_q, target;
    logic        redir_pend;
    logic        started;
    logic        ack_vld;
    logic        load_vld;
    logic        skid_load;
    logic        redir_acc;
    logic [31:0] load_word;
    ifid_t       ifid;

    // Request stays low for the first cycle after reset so a stale ack is ignored.
    assign imem_req  = started && (state == FS_FETCH);
    assign imem_addr = pc;
    assign ack_vld   = imem_ack && imem_req;
    assign pc4       = pc_plus4(pc);

    assign inst   = ifid.inst;
    assign dpc4   = ifid.dpc4;
    assign dvalid = ifid.dvalid;

    always_comb begin
        state_nxt = state;
        load_vld  = 1'b0;
        skid_load = 1'b0;
        load_word = imem_rdata;
        case (state)
            FS_FETCH: begin
                if (ack_vld) begin
                    if (wpcir) begin
                        load_vld = 1'b1;
                    end else begin
                        skid_load = 1'b1;
                        state_nxt = FS_HOLD;
                    end
                end
            end
            FS_HOLD: begin
                load_word = skid;
                if (wpcir) begin
                    load_vld  = 1'b1;
                    state_nxt = FS_FETCH;
                end
            end
            default: state_nxt = FS_FETCH;
        endcase
    end

    // Redirects only count when the branch is really resident in ID and ID is advancing.
    assign redir_acc = (pcsource != PCS_SEQ) && ifid.dvalid && wpcir;

    always_comb begin
        case (pcsource)
            PCS_BR:  target = bpc;
            PCS_JR:  target = da;
            PCS_J:   target = jpc;
            default: target = pc4;
        endcase
    end

    // PC moves only when the word at pc (the delay slot, if a branch is pending) is accepted.
    always_comb begin
        pc_nxt = pc;
        if (load_vld) begin
            if (redir_acc) begin
                pc_nxt = target;
            end else if (redir_pend) begin
                pc_nxt = tgt_q;
            end else begin
                pc_nxt = pc4;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= FS_FETCH;
            pc         <= RESET_PC;
            skid       <= 32'h0;
            tgt_q      <= 32'h0;
            redir_pend <= 1'b0;
            started    <= 1'b0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            started <= 1'b1;
            if (skid_load) begin
                skid <= imem_rdata;
            end
            if (load_vld) begin
                redir_pend <= 1'b0;
            end else if (redir_acc) begin
                redir_pend <= 1'b1;
                tgt_q      <= target;
            end
        end
    end

    if_id_reg #(
        .NOP_INST (NOP_INST)
    ) u_if_id (
        .clock  (clock),
        .resetn (resetn),
        .en     (wpcir),
        .bubble (!load_vld),
        .inst_d (load_word),
        .dpc4_d (pc4),
        .q      (ifid)
    );

endmodule

// File: tb/tb_pipe_fetch_unit.sv
// Randomized bench for pipe_fetch_unit: random memory latency, random ID stalls and redirects,
// checked against a program-order model of fetched words and delayed-branch targets.
module tb_pipe_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        resetn;
    logic        wpcir;
    logic [1:0]  pcsource;
    logic [31:0] bpc, da, jpc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic [31:0] dpc4;
    logic        dvalid;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [31:0] fq[$];
    logic [31:0] exp_next;
    logic        pend_v;
    logic [31:0] pend_tgt;
    logic        outst;
    int          lat;
    logic [31:0] oaddr;

    pipe_fetch_unit dut (
        .clock      (clock),
        .resetn     (resetn),
        .wpcir      (wpcir),
        .pcsource   (pcsource),
        .bpc        (bpc),
        .da         (da),
        .jpc        (jpc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst       (inst),
        .dpc4       (dpc4),
        .dvalid     (dvalid)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0001;
    endfunction

    function automatic logic [31:0] rand_tgt();
        logic [31:0] t;
        if ($urandom_range(0, 15) == 0) return 32'hFFFF_FFFC;
        t = $urandom_range(0, 255);
        return t << 2;
    endfunction

    task automatic model_reset();
        fq.delete();
        exp_next = RST_PC;
        pend_v   = 1'b0;
        pend_tgt = 32'h0;
        outst    = 1'b0;
        lat      = 0;
        oaddr    = 32'h0;
    endtask

    task automatic run_cycles(input int n);
        logic        pre_dvalid, acked, w;
        logic [31:0] pre_dpc4, pre_inst, ack_addr, tgt, a, a4, bl;
        logic [1:0]  pcs;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            bl = (fq.size() == 0) ? 32'd1 : 32'd0;
            check("req_vs_backlog", {31'h0, imem_req}, bl);
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            if (imem_req) begin
                if (!outst) begin
                    outst = 1'b1;
                    lat   = $urandom_range(0, 3);
                    oaddr = imem_addr;
                    check("addr_align", {30'h0, imem_addr[1:0]}, 32'h0);
                end else begin
                    check("addr_stable", imem_addr, oaddr);
                end
                if (lat == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = word_of(oaddr);
                    outst      = 1'b0;
                end else begin
                    lat--;
                end
            end
            wpcir    = ($urandom_range(0, 9) < 7);
            pcsource = 2'($urandom_range(0, 3));
            bpc      = rand_tgt();
            da       = rand_tgt();
            jpc      = rand_tgt();
            pre_dvalid = dvalid;
            pre_dpc4   = dpc4;
            pre_inst   = inst;
            acked      = imem_ack;
            ack_addr   = oaddr;
            w          = wpcir;
            pcs        = pcsource;
            tgt        = (pcs == 2'b01) ? bpc : (pcs == 2'b10) ? da : jpc;

            @(posedge clock);
            #1;
            if (acked) fq.push_back(ack_addr);
            if (pre_dvalid && w && pcs != 2'b00) begin
                pend_v   = 1'b1;
                pend_tgt = tgt;
            end
            if (w) begin
                if (fq.size() > 0) begin
                    a  = fq.pop_front();
                    a4 = a + 32'd4;
                    check("dvalid_word", {31'h0, dvalid}, 32'h1);
                    check("inst_word", inst, word_of(a));
                    check("dpc4_word", dpc4, a4);
                    check("program_order", a, exp_next);
                    exp_next = pend_v ? pend_tgt : a4;
                    pend_v   = 1'b0;
                end else begin
                    check("dvalid_bubble", {31'h0, dvalid}, 32'h0);
                    check("inst_bubble", inst, NOP);
                    check("dpc4_bubble", dpc4, pre_dpc4);
                end
            end else begin
                check("dvalid_hold", {31'h0, dvalid}, {31'h0, pre_dvalid});
                check("inst_hold", inst, pre_inst);
                check("dpc4_hold", dpc4, pre_dpc4);
            end
        end
    endtask

    initial begin
        resetn     = 1'b0;
        wpcir      = 1'b1;
        pcsource   = 2'b00;
        bpc        = 32'h0;
        da         = 32'h0;
        jpc        = 32'h0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        model_reset();

        // Reset values
        repeat (2) @(posedge clock);
        #1;
        check("rst_req", {31'h0, imem_req}, 32'h0);
        check("rst_dvalid", {31'h0, dvalid}, 32'h0);
        check("rst_inst", inst, NOP);
        check("rst_dpc4", dpc4, 32'h0);
        check("rst_addr", imem_addr, RST_PC);

        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock);
        #1;
        check("first_req", {31'h0, imem_req}, 32'h1);
        check("first_addr", imem_addr, RST_PC);
        check("first_dvalid", {31'h0, dvalid}, 32'h0);

        run_cycles(400);

        // Reset in the middle of an outstanding request
        for (int k = 0; k < 50 && !imem_req; k++) run_cycles(1);
        check("reach_req", {31'h0, imem_req}, 32'h1);
        #2;
        resetn = 1'b0;
        #1;
        check("mid_rst_req", {31'h0, imem_req}, 32'h0);
        check("mid_rst_dvalid", {31'h0, dvalid}, 32'h0);
        check("mid_rst_inst", inst, NOP);
        check("mid_rst_dpc4", dpc4, 32'h0);
        check("mid_rst_addr", imem_addr, RST_PC);

        // Stale ack arriving while the request line is still low must be ignored
        @(negedge clock);
        model_reset();
        wpcir      = 1'b1;
        pcsource   = 2'b00;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        resetn     = 1'b1;
        @(posedge clock);
        #1;
        check("stale_ack_dvalid", {31'h0, dvalid}, 32'h0);
        check("stale_ack_inst", inst, NOP);
        check("restart_req", {31'h0, imem_req}, 32'h1);
        check("restart_addr", imem_addr, RST_PC);

        run_cycles(400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
